// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - ring-oscillator edge-count measurement controller
// Optional continuous re-measurement: define RO_CONT_MEAS_EN.
module ro_measure_ctrl #(
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       gate_sel,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  // Wide enough for the 16384-cycle window and any SETTLE_CYC up to 65536.
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   timer, timer_d, win_last;
  logic [1:0]         gsel_q;
  logic               sync1, sync2, prev, rise;
  logic [CNT_W-1:0]   acc, acc_d;
  logic               sat, sat_d;
  logic               ro_en_d, busy_d, done_d;

  assign rise     = sync2 & ~prev;
  assign win_last = (TMR_W'(256) << {gsel_q, 1'b0}) - TMR_W'(1);

  always_comb begin
    state_d = state;
    timer_d = timer + TMR_W'(1);
    acc_d   = acc;
    sat_d   = sat;

    case (state)
      S_IDLE: begin
        if (start) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (timer == TMR_W'(SETTLE_CYC - 1)) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        // The final window cycle still counts; its increment reaches count via acc_d.
        if (rise) begin
          if (&acc) sat_d = 1'b1;
          else      acc_d = acc + CNT_W'(1);
        end
        if (timer == win_last) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef RO_CONT_MEAS_EN
        state_d = S_MEASURE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;

    if (state_d != state || state == S_IDLE) timer_d = '0;

    if (state_d == S_MEASURE && state != S_MEASURE) begin
      acc_d = '0;
      sat_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
`ifdef RO_CONT_MEAS_EN
    ro_en_d = busy_d;
`else
    ro_en_d = (state_d == S_SETTLE) || (state_d == S_MEASURE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_d;
      timer <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      acc      <= '0;
      sat      <= 1'b0;
      gsel_q   <= '0;
      ro_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      prev  <= sync2;
      acc   <= acc_d;
      sat   <= sat_d;
      if (state == S_IDLE && state_d == S_SETTLE) gsel_q <= gate_sel;
      ro_en <= ro_en_d;
      busy  <= busy_d;
      done  <= done_d;
      if (done_d) begin
        count    <= acc_d;
        overflow <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb/tb_ro_measure_ctrl.sv - self-checking bench for ro_measure_ctrl
module tb_ro_measure_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic        ro_in = 1'b0;
  logic        ro_en, busy, done, overflow;
  logic [11:0] count;

  int total = 0;
  int bad   = 0;
  int ro_period = 0;
  int ro_ph = 0;

  typedef struct {
    logic [1:0] gs;
    int         per;
    int         exp_cnt;
    int         exp_ovf;
  } vec_t;

  vec_t vecs[7];

  ro_measure_ctrl #(.CNT_W(12), .SETTLE_CYC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .gate_sel (gate_sel),
    .ro_in    (ro_in),
    .ro_en    (ro_en),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: period in clk cycles, transitions offset from the clock edge.
  always @(posedge clk) begin
    #3;
    if (ro_period < 2) ro_in = 1'b0;
    else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro_in = (ro_ph < ro_period / 2);
    end
  end

  function automatic int win(input logic [1:0] gs);
    return 256 << (2 * gs);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run_meas(input logic [1:0] gs, input int per, input int restart_at,
                          output int cnt, output int ovf, output int lat);
    int n;
    bit seen;
    @(negedge clk);
    gate_sel  = gs;
    ro_period = per;
    start     = 1'b1;
    n = 0;
    seen = 0;
    cnt = -1;
    ovf = -1;
    lat = -1;
    while (!seen && n < 20000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk("ro_en_after_start", ro_en, 1);
        chk("busy_after_start", busy, 1);
        gate_sel = ~gs;
      end
      if (n == restart_at) start = 1'b1;
      if (done) begin
        seen = 1;
        lat  = n;
        cnt  = count;
        ovf  = overflow;
        chk("ro_en_in_done", ro_en, 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    int cnt, ovf, lat, tol, w, lo, hi, pulses, n;
    logic [1:0] gs;
    int per;

    vecs[0] = '{2'd0, 4, 64, 0};
    vecs[1] = '{2'd0, 2, 128, 0};
    vecs[2] = '{2'd1, 8, 128, 0};
    vecs[3] = '{2'd0, 0, 0, 0};
    vecs[4] = '{2'd2, 32, 128, 0};
    vecs[5] = '{2'd3, 2, 4095, 1};
    vecs[6] = '{2'd0, 8, 32, 0};

    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

`ifdef RO_CONT_MEAS_EN
    @(negedge clk);
    gate_sel = 2'd1;
    ro_period = 8;
    start = 1'b1;
    n = 0;
    pulses = 0;
    lat = 0;
    tol = 0;
    while (pulses < 3 && n < 6000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (!ro_en) tol++;
      if (done) begin
        if (pulses == 0) chk("cont_first_latency", n, 17 + 1024);
        else chk("cont_period", n - lat, 1025);
        chk_rng("cont_count", count, 127, 129);
        lat = n;
        pulses++;
      end
    end
    chk("cont_pulses", pulses, 3);
    chk("cont_ro_en_low_cycles", tol, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("cont_abort_ro_en", ro_en, 0);
    chk("cont_abort_busy", busy, 0);
`else
    for (int i = 0; i < 7; i++) begin
      run_meas(vecs[i].gs, vecs[i].per, 0, cnt, ovf, lat);
      tol = vecs[i].exp_ovf ? 0 : 1;
      chk($sformatf("vec%0d_latency", i), lat, 17 + win(vecs[i].gs));
      chk_rng($sformatf("vec%0d_count", i), cnt, vecs[i].exp_cnt - tol, vecs[i].exp_cnt + tol);
      chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
    end

    for (int t = 0; t < 5; t++) begin
      gs  = 2'($urandom_range(0, 2));
      per = $urandom_range(2, 20);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_meas(gs, per, 0, cnt, ovf, lat);
      w  = win(gs);
      lo = w / per;
      hi = (w + per - 1) / per;
      chk($sformatf("rnd%0d_latency", t), lat, 17 + w);
      chk_rng($sformatf("rnd%0d_count_p%0d_g%0d", t, per, gs), cnt, lo, hi);
      chk($sformatf("rnd%0d_ovf", t), ovf, 0);
    end

    // Re-establish a known count of exactly 32 before the abort sequences.
    run_meas(2'd0, 8, 50, cnt, ovf, lat);
    chk("restart_ignored_latency", lat, 273);
    chk("restart_ignored_count", cnt, 32);
    run_meas(2'd0, 8, 273, cnt, ovf, lat);
    chk("start_in_done_latency", lat, 273);
    repeat (5) @(negedge clk);
    chk("start_in_done_ignored", busy, 0);

    @(negedge clk);
    gate_sel = 2'd1;
    ro_period = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_done", done, 0);
    chk("abort_count_kept", count, 32);
    pulses = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_stays_idle", pulses, 0);

    @(negedge clk);
    gate_sel = 2'd0;
    ro_period = 4;
    start = 1'b1;
    n = 0;
    while (n < 272) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_at_expiry_done", done, 0);
    chk("abort_at_expiry_busy", busy, 0);
    chk("abort_at_expiry_count", count, 32);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    @(negedge clk);
    gate_sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_ro_en", ro_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_ro_en", ro_en, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
